// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage.
//   Contents:
//     RESET_PC_DEF  default first fetch address after reset
//     NOP_INST      instruction word shown to DEC when no entry is valid
//     PC_STEP       byte increment between sequential instruction words
//     fetch_entry_t one prefetch queue entry {pc, inst}
//     fetch_state_e RUN (no stale responses owed) / DRAIN (stale responses owed)
//   Optional feature macro used by inst_fetch: FETCH_PERF_EN (not referenced here).
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   Handshake: a request is issued in a cycle where iMemReq && iMemRdy are
//   both high at the rising clock edge; iMemAddr must be held valid with
//   iMemReq. iMemRValid has no back-pressure: each cycle it is high carries
//   exactly one response word on iMemRData, responses return in request
//   order with latency of at least one cycle.
//   Signals:
//     iMemReq     fetch -> mem   request valid
//     iMemAddr    fetch -> mem   32-bit word-aligned fetch address
//     iMemRdy     mem -> fetch   memory accepts the request this cycle
//     iMemRValid  mem -> fetch   read data valid
//     iMemRData   mem -> fetch   32-bit instruction word
//   Modports: master (fetch side), slave (memory side).
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        iMemReq;
  logic [31:0] iMemAddr;
  logic        iMemRdy;
  logic        iMemRValid;
  logic [31:0] iMemRData;

  modport master (
    output iMemReq, iMemAddr,
    input  iMemRdy, iMemRValid, iMemRData
  );

  modport slave (
    input  iMemReq, iMemAddr,
    output iMemRdy, iMemRValid, iMemRData
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO of DEPTH fetch_entry_t entries (64 bits each).
//   No bypass: a word pushed into an empty queue appears on head next cycle.
//   Flush empties the queue and takes priority over push/pop.
//   Ports:
//     clk, rstn   clock, synchronous active-low reset
//     push        write push_data at the tail
//     push_data   entry to write
//     pop         drop the head entry
//     flush       discard all entries
//     head        current head entry (undefined content when empty)
//     count       number of stored entries (0..DEPTH)
//     empty, full status flags
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so they wrap naturally at DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage: owns the fetch PC, issues in-order requests to
//   instruction memory, buffers returned words with their PCs in a prefetch
//   queue and presents {PC, inst} to DEC. Honours DEC pause and redirects on a
//   taken branch/jump, discarding wrong-path responses still in flight.
//   Parameters: DEPTH (queue entries = max in-flight, power of 2, >=2),
//               RESET_PC (first fetch address).
//   Ports:
//     clk, rstn        clock, synchronous active-low reset
//     i_FET_pause      DEC stall; head does not advance
//     i_FET_redirect   taken branch/jump; highest priority
//     i_FET_target     redirect target PC
//     mem              inst_fetch_if.master instruction-memory bus
//     o_FET_PC/inst    head entry to DEC, 0/NOP when not valid
//     o_FET_valid      head entry valid
//     o_FET_state      RUN/DRAIN state for observation
//   Optional build macro FETCH_PERF_EN adds o_FET_bubbleCnt (cycles with
//   !valid && !pause) and o_FET_flushCnt (redirects), 32-bit wrapping.
// -----------------------------------------------------------------------------
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_FET_pause,
  input  logic               i_FET_redirect,
  input  logic [31:0]        i_FET_target,
  inst_fetch_if.master       mem,
  output logic [31:0]        o_FET_PC,
  output logic [31:0]        o_FET_inst,
  output logic               o_FET_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0]        o_FET_bubbleCnt,
  output logic [31:0]        o_FET_flushCnt,
`endif
  output fetch_state_e       o_FET_state
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  fetch_state_e  state_q, state_d;

  fetch_entry_t  q_head;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full;
  logic          push, pop, issue, rvalid, stale, head_valid;
  logic [CW:0]   used;

  // Credit rule: requests in flight plus buffered words never exceed DEPTH,
  // so every response always has a queue slot.
  assign used         = (CW+1)'(inflight_q) + (CW+1)'(q_count);
  assign mem.iMemReq  = rstn && !i_FET_redirect && (used < (CW+1)'(DEPTH));
  assign mem.iMemAddr = fetch_pc_q;

  assign rvalid     = mem.iMemRValid;
  assign issue      = mem.iMemReq && mem.iMemRdy;
  assign stale      = (drop_q != '0);
  assign head_valid = rstn && !q_empty;
  assign push       = rvalid && !stale && !i_FET_redirect;
  assign pop        = head_valid && !i_FET_pause && !i_FET_redirect;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ('{pc: resp_pc_q, inst: mem.iMemRData}),
    .pop       (pop),
    .flush     (i_FET_redirect),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (i_FET_redirect) begin
      // Every request still outstanding after this cycle is wrong-path.
      fetch_pc_d = i_FET_target;
      resp_pc_d  = i_FET_target;
      inflight_d = inflight_q - CW'(rvalid);
      drop_d     = inflight_q - CW'(rvalid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      inflight_d = inflight_q + CW'(issue) - CW'(rvalid);
      if (rvalid) begin
        if (stale) drop_d    = drop_q - CW'(1);
        else       resp_pc_d = resp_pc_q + PC_STEP;
      end
    end
    state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
    end
  end

  assign o_FET_valid = head_valid;
  assign o_FET_PC    = head_valid ? q_head.pc   : 32'h0;
  assign o_FET_inst  = head_valid ? q_head.inst : NOP_INST;
  assign o_FET_state = state_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && q_full));

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + 32'(!head_valid && !i_FET_pause);
    flush_cnt_d  = flush_cnt_q + 32'(i_FET_redirect);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign o_FET_bubbleCnt = bubble_cnt_q;
  assign o_FET_flushCnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Bench for inst_fetch: an instruction memory returning addr>>2 with a
//   configurable in-order latency, a queue-level model of the fetch stage
//   checked on every falling edge, and directed scenarios with literal
//   expectations. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        pause, redirect;
  logic [31:0] target;
  logic [31:0] o_pc, o_inst;
  logic        o_valid;
  fetch_state_e o_state;
`ifdef FETCH_PERF_EN
  logic [31:0] o_bub, o_fl;
`endif

  always #5 clk = ~clk;

  inst_fetch_if mem_if ();

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_FET_pause    (pause),
    .i_FET_redirect (redirect),
    .i_FET_target   (target),
    .mem            (mem_if),
    .o_FET_PC       (o_pc),
    .o_FET_inst     (o_inst),
    .o_FET_valid    (o_valid),
`ifdef FETCH_PERF_EN
    .o_FET_bubbleCnt(o_bub),
    .o_FET_flushCnt (o_fl),
`endif
    .o_FET_state    (o_state)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory ----------------
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] mem_a[$];
  int          mem_due[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      mem_if.iMemRValid = 1'b1;
      mem_if.iMemRData  = mem_a[0] >> 2;
    end else begin
      mem_if.iMemRValid = 1'b0;
      mem_if.iMemRData  = 32'hdead_beef;
    end
  end

  // ---------------- model + scoreboard ----------------
  logic [31:0] m_fetch, m_resp;
  logic [63:0] exp_q[$];
  int          m_inflight, m_drop, m_bub, m_fl;
  bit          m_init = 1'b0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];

  always @(negedge clk) begin
    logic e_valid, e_req, rv;
    e_valid = rstn && (exp_q.size() > 0);
    e_req   = rstn && !redirect && (m_inflight + exp_q.size() < DEPTH);
    if (m_init) begin
      chk("valid", 32'(o_valid), 32'(e_valid));
      chk("pc",    o_pc,   e_valid ? exp_q[0][63:32] : 32'h0);
      chk("inst",  o_inst, e_valid ? exp_q[0][31:0]  : 32'h0);
      chk("req",   32'(mem_if.iMemReq), 32'(e_req));
      chk("addr",  mem_if.iMemAddr, m_fetch);
      chk("state", 32'(o_state), (m_drop != 0) ? 32'(ST_DRAIN) : 32'(ST_RUN));
`ifdef FETCH_PERF_EN
      chk("bubble_cnt", o_bub, m_bub);
      chk("flush_cnt",  o_fl,  m_fl);
`endif
      if (rstn && o_valid && !pause && !redirect) begin
        chk("inst_is_word_of_pc", o_inst, o_pc >> 2);
        pop_pc.push_back(o_pc);
        pop_inst.push_back(o_inst);
      end
    end
    if (!rstn) begin
      m_fetch = 32'h0; m_resp = 32'h0; exp_q.delete();
      m_inflight = 0; m_drop = 0; m_bub = 0; m_fl = 0;
      mem_a.delete(); mem_due.delete();
      m_init = 1'b1;
    end else if (m_init) begin
      rv = mem_if.iMemRValid;
      if (!e_valid && !pause) m_bub++;
      if (redirect) begin
        exp_q.delete();
        m_inflight = m_inflight - int'(rv);
        m_drop     = m_inflight;
        m_fetch    = target;
        m_resp     = target;
        m_fl++;
      end else begin
        if (e_valid && !pause) void'(exp_q.pop_front());
        if (rv) begin
          m_inflight--;
          if (m_drop > 0) m_drop--;
          else begin
            exp_q.push_back({m_resp, mem_if.iMemRData});
            m_resp = m_resp + 32'd4;
          end
        end
        if (e_req && mem_if.iMemRdy) begin
          m_fetch = m_fetch + 32'd4;
          m_inflight++;
        end
      end
      cmp_cnt++;
      if (exp_q.size() > DEPTH) begin
        err_cnt++;
        $display("FAIL queue_bound: got %0d entries expected at most %0d", exp_q.size(), DEPTH);
      end
      // memory side of the bus
      if (mem_if.iMemRValid && mem_a.size() > 0) begin
        void'(mem_a.pop_front());
        void'(mem_due.pop_front());
      end
      if (mem_if.iMemReq && mem_if.iMemRdy) begin
        mem_a.push_back(mem_if.iMemAddr);
        mem_due.push_back(cyc + lat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] saved_addr;
  bit          found;

  initial begin
    rstn = 1'b0; pause = 1'b0; redirect = 1'b0; target = 32'h0;
    mem_if.iMemRdy = 1'b0; mem_if.iMemRValid = 1'b0; mem_if.iMemRData = 32'h0;

    // 1: reset values, then sequential fetch with 1-cycle memory
    step(2);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_req",   32'(mem_if.iMemReq), 32'h0);
    chk("rst_pc",    o_pc, 32'h0);
    chk("rst_inst",  o_inst, 32'h0);
    chk("rst_addr",  mem_if.iMemAddr, 32'h0);
    realign();
    rstn = 1'b1; mem_if.iMemRdy = 1'b1; lat = 1;
    pop_pc.delete(); pop_inst.delete();
    step(2);
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("t6_bubbles_after_start", o_bub, 32'd2);
    chk("t6_flush_after_start",   o_fl,  32'd0);
    realign();
`endif
    step(6);
    chk("t1_npop", 32'(pop_pc.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
      chk("t1_pc",   pop_pc[i],   32'(i * 4));
      chk("t1_inst", pop_inst[i], 32'(i));
    end

    // 2: pause with full queue, then release
    pause = 1'b1;
    do_reset();
    step(10);
    @(negedge clk);
    chk("t2_req_low",  32'(mem_if.iMemReq), 32'h0);
    chk("t2_valid",    32'(o_valid), 32'h1);
    chk("t2_head_pc",  o_pc, 32'h0);
    realign();
    pop_pc.delete(); pop_inst.delete();
    pause = 1'b0;
    step(10);
    chk("t2_npop", 32'(pop_pc.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < pop_pc.size(); i++) chk("t2_order", pop_pc[i], 32'(i * 4));

    // 3: three requests in flight, redirect to 0x100
    lat = 4;
    do_reset();
    step(3);
    redirect = 1'b1; target = 32'h100;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_drain", 32'(o_state), 32'(ST_DRAIN));
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (o_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("t3_found", 32'(found), 32'h1);
    chk("t3_first_pc",   o_pc,   32'h100);
    chk("t3_first_inst", o_inst, 32'h40);
    realign();

    // 4: redirect while a response arrives and the head pops
    lat = 2;
    do_reset();
    step(8);
    redirect = 1'b1; target = 32'h200;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_empty", 32'(o_valid), 32'h0);
    chk("t4_drain", 32'(o_state), 32'(ST_DRAIN));
    realign();
    step(6);

    // 5: memory not ready -> stable address and bubbles; reset mid-stream
    mem_if.iMemRdy = 1'b0;
    step(4);
    @(negedge clk);
    saved_addr = mem_if.iMemAddr;
    for (int i = 0; i < 5; i++) begin
      chk("t5_addr_stable", mem_if.iMemAddr, saved_addr);
      chk("t5_bubble_valid", 32'(o_valid), 32'h0);
      chk("t5_bubble_inst",  o_inst, 32'h0);
      @(negedge clk);
    end
    realign();
    mem_if.iMemRdy = 1'b1;
    step(2);
    do_reset();
    @(negedge clk);
    chk("t5_addr_after_rst", mem_if.iMemAddr, 32'h0);
    chk("t5_valid_after_rst", 32'(o_valid), 32'h0);
    realign();
    step(5);

    // PC wrap-around at 2^32
    redirect = 1'b1; target = 32'hFFFF_FFF8;
    step(1);
    redirect = 1'b0;
    step(12);

    // mixed traffic
    for (int ph = 0; ph < 2; ph++) begin
      lat = (ph == 0) ? 2 : 1;
      for (int i = 0; i < 150; i++) begin
        mem_if.iMemRdy = ($urandom_range(0, 3) != 0);
        pause          = ($urandom_range(0, 3) == 0);
        redirect       = ($urandom_range(0, 15) == 0);
        target         = $urandom() & 32'hFFFF_FFFC;
        step(1);
      end
    end
    redirect = 1'b0; pause = 1'b0; mem_if.iMemRdy = 1'b1;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
